core_lp_arbiter: RTL

- Successor to the core stall monitor. Keeps a per-core table of active LP and timestamp.
- Stalls any core that is dispatched an event for an LP already held by another active core.
- On each event return, a sequential scan releases the waiting core with the smallest timestamp, with a deterministic tie-break and a ready/valid return handshake.
- Also reports the GVT candidate (minimum active timestamp), forwards per-LP history depth to cores, and counts conflicts. Sits between the event queue and the core array.

---
 rtl/core_lp_arbiter_if.sv | 39 +++
 rtl/core_lp_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_lp_arbiter_if.sv
// core_lp_arbiter_if: event-queue / core-array handshake bundle for the LP arbiter.
//   send_*       : queue -> arbiter dispatch (core id, message carrying LP and time)
//   rcv_*        : core -> arbiter return with ready/valid (rcv_rdy from arbiter)
//   stall        : per-core stall
//   core_hist_cnt: per-core LP history depth, core p at [p*NB_HIST_DEPTH +: NB_HIST_DEPTH]
//   min_time(_vld), conflict_cnt, err : status outputs
// master = queue/core side, slave = arbiter.
interface core_lp_arbiter_if #(
    parameter int NUM_CORE      = 4,
    parameter int NB_COREID     = $clog2(NUM_CORE),
    parameter int TIME_WID      = 16,
    parameter int MSG_WID       = 32,
    parameter int NB_HIST_DEPTH = 4,
    parameter int CNT_WID       = 16
);
    logic                              send_vld;
    logic [NB_COREID-1:0]              send_core_id;
    logic [MSG_WID-1:0]                send_msg;
    logic                              rcv_vld;
    logic                              rcv_rdy;
    logic [NB_COREID-1:0]              rcv_core_id;
    logic [MSG_WID-1:0]                rcv_msg;
    logic [NUM_CORE-1:0]               stall;
    logic [NB_HIST_DEPTH*NUM_CORE-1:0] core_hist_cnt;
    logic [TIME_WID-1:0]               min_time;
    logic                              min_time_vld;
    logic [CNT_WID-1:0]                conflict_cnt;
    logic                              err;

    modport master (
        output send_vld, send_core_id, send_msg, rcv_vld, rcv_core_id, rcv_msg,
        input  rcv_rdy, stall, core_hist_cnt, min_time, min_time_vld, conflict_cnt, err
    );

    modport slave (
        input  send_vld, send_core_id, send_msg, rcv_vld, rcv_core_id, rcv_msg,
        output rcv_rdy, stall, core_hist_cnt, min_time, min_time_vld, conflict_cnt, err
    );
endinterface

// File: rtl/core_lp_arbiter.sv
// core_lp_arbiter: per-core LP/timestamp table that stalls cores dispatched an
// event for an LP held by another active core, and on each return releases the
// waiting core with the smallest timestamp (lowest id on ties) via a sequential
// scan. Also reports the GVT candidate, forwards LP history depth and counts
// conflicts.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : core_lp_arbiter_if.slave (dispatch, return handshake, status)
module core_lp_arbiter #(
    parameter int NUM_CORE      = 4,
    parameter int NB_COREID     = $clog2(NUM_CORE),
    parameter int NUM_LP        = 8,
    parameter int NB_LPID       = $clog2(NUM_LP),
    parameter int TIME_WID      = 16,
    parameter int MSG_WID       = 32,
    parameter int NB_HIST_DEPTH = 4,
    parameter int CNT_WID       = 16
) (
    input  logic               clk,
    input  logic               reset,
    core_lp_arbiter_if.slave   bus
);
    localparam logic [NB_COREID-1:0] LAST_IDX = NB_COREID'(NUM_CORE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

    state_t state_q, state_d;

    logic [NUM_CORE-1:0]                    act_q, act_d, stl_q, stl_d;
    logic [NUM_CORE-1:0][NB_LPID-1:0]       lp_q, lp_d;
    logic [NUM_CORE-1:0][TIME_WID-1:0]      ts_q, ts_d;
    logic [NUM_LP-1:0][NB_HIST_DEPTH-1:0]   hist_q, hist_d;
    logic [NUM_CORE-1:0][NB_HIST_DEPTH-1:0] hcnt_q, hcnt_d;
    logic [NB_LPID-1:0]                     held_q, held_d;
    logic [NB_COREID-1:0]                   idx_q, idx_d, best_q, best_d;
    logic [TIME_WID-1:0]                    best_ts_q, best_ts_d;
    logic                                   best_vld_q, best_vld_d;
    logic [TIME_WID-1:0]                    min_time_q, min_time_d;
    logic                                   min_vld_q, min_vld_d;
    logic [CNT_WID-1:0]                     cnt_q, cnt_d;
    logic                                   err_q, err_d;

    logic                     rcv_rdy, scan_en, grant_en;
    logic                     rcv_acc, rcv_ok, has_waiter, start_scan;
    logic                     conflict, scan_hit, grant_ok, min_found;
    logic [NB_COREID-1:0]     rc, sc;
    logic [NB_LPID-1:0]       rcv_lp, send_lp;
    logic [TIME_WID-1:0]      send_ts;
    logic [NB_HIST_DEPTH-1:0] rcv_hist;
    logic                     unused_msg_bits;

    assign rc       = bus.rcv_core_id;
    assign sc       = bus.send_core_id;
    assign rcv_lp   = lp_q[rc];
    assign send_lp  = bus.send_msg[TIME_WID +: NB_LPID];
    assign send_ts  = bus.send_msg[TIME_WID-1:0];
    assign rcv_hist = bus.rcv_msg[MSG_WID-1 -: NB_HIST_DEPTH];
    assign unused_msg_bits = ^{bus.send_msg, bus.rcv_msg};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_scan) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = GRANT;
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rcv_rdy  = (state_q == IDLE) && !reset;
        scan_en  = (state_q == SCAN);
        grant_en = (state_q == GRANT);
    end

    // ---------------- Decode of this cycle's events ----------------
    always_comb begin
        rcv_acc    = bus.rcv_vld && rcv_rdy;
        rcv_ok     = rcv_acc && act_q[rc];
        has_waiter = 1'b0;
        conflict   = 1'b0;
        for (int k = 0; k < NUM_CORE; k++) begin
            if (NB_COREID'(k) != rc && act_q[k] && stl_q[k] && lp_q[k] == rcv_lp)
                has_waiter = 1'b1;
            // A core returning this cycle no longer holds its LP.
            if (NB_COREID'(k) != sc && act_q[k] && !(rcv_ok && rc == NB_COREID'(k))
                && lp_q[k] == send_lp)
                conflict = 1'b1;
        end
        start_scan = rcv_ok && has_waiter;
        scan_hit   = act_q[idx_q] && stl_q[idx_q] && lp_q[idx_q] == held_q;
        // Best candidate may have returned or been redispatched during the scan.
        grant_ok   = best_vld_q && act_q[best_q] && stl_q[best_q] && lp_q[best_q] == held_q;
    end

    // ---------------- Table / scan datapath ----------------
    always_comb begin
        act_d      = act_q;
        stl_d      = stl_q;
        lp_d       = lp_q;
        ts_d       = ts_q;
        hist_d     = hist_q;
        hcnt_d     = hcnt_q;
        held_d     = held_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_ts_d  = best_ts_q;
        best_vld_d = best_vld_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        if (rcv_acc) begin
            if (!act_q[rc]) begin
                err_d = 1'b1;
            end else begin
                act_d[rc]      = 1'b0;
                stl_d[rc]      = 1'b0;
                hist_d[rcv_lp] = rcv_hist;
            end
        end

        if (start_scan) begin
            held_d     = rcv_lp;
            idx_d      = '0;
            best_vld_d = 1'b0;
        end

        if (scan_en) begin
            // Strict compare keeps the lowest id on equal timestamps.
            if (scan_hit && (!best_vld_q || ts_q[idx_q] < best_ts_q)) begin
                best_d     = idx_q;
                best_ts_d  = ts_q[idx_q];
                best_vld_d = 1'b1;
            end
            idx_d = idx_q + 1'b1;
        end

        if (grant_en && grant_ok) begin
            stl_d[best_q]  = 1'b0;
            hcnt_d[best_q] = hist_q[held_q];
        end

        // Dispatch last so it wins the entry over a same-cycle return or grant.
        if (bus.send_vld) begin
            if (act_q[sc] || (rcv_acc && rc == sc))
                err_d = 1'b1;
            act_d[sc] = 1'b1;
            lp_d[sc]  = send_lp;
            ts_d[sc]  = send_ts;
            stl_d[sc] = conflict;
            if (conflict) begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                hcnt_d[sc] = hist_q[send_lp];
            end
        end
    end

    // GVT candidate from the registered table.
    always_comb begin
        min_time_d = '0;
        min_found  = 1'b0;
        for (int k = 0; k < NUM_CORE; k++) begin
            if (act_q[k] && (!min_found || ts_q[k] < min_time_d)) begin
                min_time_d = ts_q[k];
                min_found  = 1'b1;
            end
        end
        min_vld_d = |act_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= '0;
            stl_q      <= '0;
            lp_q       <= '0;
            ts_q       <= '0;
            hist_q     <= '0;
            hcnt_q     <= '0;
            held_q     <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_ts_q  <= '0;
            best_vld_q <= 1'b0;
            min_time_q <= '0;
            min_vld_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            act_q      <= act_d;
            stl_q      <= stl_d;
            lp_q       <= lp_d;
            ts_q       <= ts_d;
            hist_q     <= hist_d;
            hcnt_q     <= hcnt_d;
            held_q     <= held_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_ts_q  <= best_ts_d;
            best_vld_q <= best_vld_d;
            min_time_q <= min_time_d;
            min_vld_q  <= min_vld_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.rcv_rdy       = rcv_rdy;
    assign bus.stall         = stl_q;
    assign bus.core_hist_cnt = hcnt_q;
    assign bus.min_time      = min_time_q;
    assign bus.min_time_vld  = min_vld_q;
    assign bus.conflict_cnt  = cnt_q;
    assign bus.err           = err_q;
endmodule
